fifo_burst_reader: RTL

- Downstream consumer of the 8-bit sync FIFO. It is the read-side counterpart of the watermark write FSM.
- Watches fifo_words and stays idle until the FIFO reaches a high watermark. It then bursts reads until the count falls to a low watermark.
- Read bytes go into a 2-entry output buffer and are presented on a valid/ready stream, so downstream backpressure never loses data.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/out_skid_buf.sv | 65 ++++++
 rtl/fifo_burst_reader.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit sync FIFO, its watermark write FSM and
// the burst reader.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

    // Room for one more read. A pop in this cycle frees a slot before the
    // read data lands two edges later, so it counts as credit.
    // Expressed as occ + pend < 2 + pop to avoid underflow.
    function automatic logic has_credit(input logic [1:0] occ,
                                        input logic       pend,
                                        input logic       pop);
        return ({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry output buffer for a valid/ready stream. The head entry is
// presented on data_out_o and stays put until popped.
module out_skid_buf
    import fifo_pkg::*;
#(
    parameter int W = fifo_pkg::DATA_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_in_i,
    input  logic         pop_i,
    output logic [W-1:0] data_out_o,
    output logic         valid_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_d;
    logic         do_pop;
    logic         do_push;

    // A pop on an empty buffer is ignored; a push while full is dropped
    // rather than corrupting the head (callers are expected to hold credit).
    assign do_pop  = pop_i && (occ_q != 2'd0);
    assign do_push = push_i && ((occ_q != 2'd2) || do_pop);

    // occupancy next state: push and pop together cancel
    always_comb begin
        occ_d = occ_q;
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // storage, pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_in_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign data_out_o = mem_q[rd_ptr_q];
    assign valid_o    = (occ_q != 2'd0);
    assign occ_o      = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for the 8-bit sync FIFO. Idles until the FIFO
// reaches HIGH_WM, then reads one byte per cycle until occupancy falls to
// LOW_WM. Bytes land in a 2-entry buffer and leave on a valid/ready stream;
// reads are only issued when the buffer is guaranteed room, so backpressure
// never drops data.
// Optional build macro FIFO_BURST_READER_STATS_EN adds burst_count/burst_done.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W  = fifo_pkg::DATA_W,
    parameter int CNT_W   = fifo_pkg::CNT_W,
    parameter int HIGH_WM = 6,
    parameter int LOW_WM  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_words,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    output logic [7:0]        burst_count,
    output logic              burst_done
`endif
);

    rd_state_t  state_q;
    rd_state_t  state_d;
    logic       rd_pend_q;
    logic [1:0] occ;
    logic       out_pop;
    logic       words_hi;
    logic       words_lo;

    assign out_pop  = out_valid && out_ready;
    assign words_hi = (fifo_words >= CNT_W'(HIGH_WM));
    assign words_lo = (fifo_words <= CNT_W'(LOW_WM));

    // next state and read strobe; exit always uses the live occupancy so
    // concurrent upstream writes stretch the burst
    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (words_hi) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                fifo_rd_en = !rst && !fifo_empty && !words_lo &&
                             has_credit(occ, rd_pend_q, out_pop);
                if (words_lo || fifo_empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register and one-deep read-latency tracker; a read in flight at
    // reset is dropped on purpose
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= fifo_rd_en;
        end
    end

    assign busy = (state_q == BURST);

    // FIFO data arrives the cycle after the strobe and is captured here
    out_skid_buf #(
        .W (DATA_W)
    ) u_out_buf (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (rd_pend_q),
        .data_in_i  (fifo_data),
        .pop_i      (out_pop),
        .data_out_o (out_data),
        .valid_o    (out_valid),
        .occ_o      (occ)
    );

`ifdef FIFO_BURST_READER_STATS_EN
    logic [7:0] burst_count_q;
    logic [7:0] burst_count_d;
    logic       burst_done_q;

    // bytes delivered since the burst started; trailing pops after the
    // burst ends still belong to it
    always_comb begin
        burst_count_d = burst_count_q;
        if ((state_q == IDLE) && (state_d == BURST)) begin
            burst_count_d = 8'd0;
        end else if (out_pop && (burst_count_q != 8'hFF)) begin
            burst_count_d = burst_count_q + 8'd1;
        end
    end

    // stats registers; done pulses in the first IDLE cycle after a burst
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_count_q <= 8'd0;
            burst_done_q  <= 1'b0;
        end else begin
            burst_count_q <= burst_count_d;
            burst_done_q  <= (state_q == BURST) && (state_d == IDLE);
        end
    end

    assign burst_count = burst_count_q;
    assign burst_done  = burst_done_q;
`endif

endmodule
